attractor_sweeper: RTL
======================

Name: attractor_sweeper

Overview:
- Sequencer that sits upstream of gene_net and downstream of fixed_point_checker / cycle_checker.
- It walks every 8-bit seed state and iterates the network from each seed, feeding next_status back as status.
- It classifies each trajectory as FIXED, CYCLE or TIMEOUT and streams one result record per seed over a valid/ready handshake.
- It keeps per-class totals for the whole sweep.

Parameters:
- MAX_STEPS, 256: maximum network iterations per seed before the seed is classified TIMEOUT. Legal range 2..511.
- FIRST_SEED, 8'h00: first seed of the sweep. The sweep always ends at 8'hFF.

Ports:
- clk  input  1  single system clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- status  output  [0:7]  state driven into gene_net.
- next_status  input  [0:7]  gene_net output for the current status.
- is_fixed  input  1  fixed_point_checker result.
- is_cycle  input  1  cycle_checker result.
- chk_reset  output  1  active-high reset to both checkers.
- result_valid  output  1  result record is valid.
- result_ready  input  1  consumer accepts the record.
- result_seed  output  [0:7]  seed of the record.
- result_class  output  2  01=FIXED, 10=CYCLE, 11=TIMEOUT; 00 is never emitted.
- result_steps  output  9  RUN cycles elapsed at classification, in 1..MAX_STEPS.
- fixed_count, cycle_count, timeout_count  output  9 each  per-class totals for the current sweep.
- busy  output  1  high in LOAD, RUN and REPORT.
- done  output  1  high in DONE.

Behaviour:
- Reset (reset=0 on a clk edge), taking priority over everything:
  - state goes to IDLE.
  - status, result_seed, result_class, result_steps, the step counter and all three totals go to 0.
  - result_valid, busy and done go to 0.
  - chk_reset goes to 1.
  - Reset in any state, including mid-RUN or mid-REPORT, aborts the sweep; no record or total survives.
- IDLE:
  - chk_reset=1.
  - On start=1: clear the totals, seed<=FIRST_SEED, go to LOAD.
- LOAD (exactly 1 cycle):
  - status<=seed, step<=0, chk_reset=1.
  - Next state is RUN.
- RUN:
  - chk_reset=0.
  - Each cycle: status<=next_status, step<=step+1.
  - Classification is evaluated every cycle with step>=1. The step==0 cycle is ignored because the checkers are still leaving reset.
  - Priority order: is_fixed gives FIXED; else is_cycle gives CYCLE; else step==MAX_STEPS-1 gives TIMEOUT.
  - On classification:
    - Latch result_seed=seed, result_class, and result_steps=step+1.
    - Go to REPORT; status does not update on that edge.
- REPORT:
  - result_valid=1.
  - All result_* outputs and status stay stable until result_ready=1 is sampled.
  - On handshake (valid and ready in the same cycle):
    - Increment the matching total.
    - Drop result_valid on the next edge.
    - If seed==8'hFF, go to DONE; otherwise seed<=seed+1 and go to LOAD.
  - result_ready while valid=0 has no effect.
  - There is no combinational path from result_ready to result_valid.
- DONE:
  - done=1 and chk_reset=1.
  - Totals hold until start=1, which clears them and restarts from FIRST_SEED as in IDLE.
- start while busy=1 is ignored.
- Arithmetic and width rules:
  - Totals are 9-bit and saturate at 511, which is unreachable for a full sweep (maximum 256).
  - The seed counter is 8-bit; the seed==8'hFF test precedes the increment, so there is no wrap.
  - Invariant in DONE: fixed_count + cycle_count + timeout_count = 256 - FIRST_SEED.
- Latency per seed is 1 (LOAD) + result_steps (RUN) + at least 1 (REPORT) cycles.
- is_fixed and is_cycle asserted together always classify FIXED.

Test Plan:
- Identity network stub (next_status=status, checkers real), MAX_STEPS=256, result_ready held 1, start pulse:
  - required: 256 records with seeds 00..FF in order, every result_class=01.
  - required: done=1 with fixed_count=256, cycle_count=0, timeout_count=0.
- Complement stub (next_status=~status):
  - required: every record has result_class=10 with result_steps<=4.
  - required: cycle_count=256 at DONE.
- Checker stubs tied to 0, MAX_STEPS=8:
  - required: every record has result_class=11 and result_steps=8.
  - required: timeout_count=256.
- Backpressure: hold result_ready=0 for 5 cycles in REPORT for seed 8'h2A.
  - required: result_valid=1 and result_seed/result_class/result_steps/status stable throughout.
  - required: the total increments exactly once, on the ready cycle.
- Drive reset=0 for one cycle in RUN at seed 8'h10.
  - required: the next cycle shows IDLE, all outputs 0, chk_reset=1, totals 0.
  - required: a new start sweeps again from 8'h00.
- Pulse start while busy, then pulse start in DONE.
  - required: the start while busy is ignored.
  - required: the start in DONE clears the totals and restarts.
- Force is_fixed=is_cycle=1 at step 3:
  - required: result_class=01 and result_steps=4.

Source files
------------

// File: rtl/attractor_sweeper.sv
// Walks every seed from FIRST_SEED to 8'hFF through gene_net, classifies each
// trajectory as FIXED / CYCLE / TIMEOUT and streams one record per seed.
module attractor_sweeper #(
  parameter int unsigned MAX_STEPS  = 256,
  parameter logic [7:0]  FIRST_SEED = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [0:7] status,
  input  logic [0:7] next_status,
  input  logic       is_fixed,
  input  logic       is_cycle,
  output logic       chk_reset,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [0:7] result_seed,
  output logic [1:0] result_class,
  output logic [8:0] result_steps,
  output logic [8:0] fixed_count,
  output logic [8:0] cycle_count,
  output logic [8:0] timeout_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_REPORT,
    ST_DONE
  } state_t;

  localparam logic [8:0] LAST_STEP   = 9'(MAX_STEPS - 1);
  localparam logic [1:0] CLS_FIXED   = 2'b01;
  localparam logic [1:0] CLS_CYCLE   = 2'b10;
  localparam logic [1:0] CLS_TIMEOUT = 2'b11;

  state_t     state;
  state_t     state_next;
  logic [7:0] seed;
  logic [8:0] step;
  logic       classify;
  logic [1:0] class_next;
  logic       handshake;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Step 0 is skipped: the checkers are only just leaving reset on that cycle.
  always_comb begin
    classify   = 1'b0;
    class_next = CLS_TIMEOUT;
    if (state == ST_RUN && step != 9'd0) begin
      if (is_fixed) begin
        classify   = 1'b1;
        class_next = CLS_FIXED;
      end else if (is_cycle) begin
        classify   = 1'b1;
        class_next = CLS_CYCLE;
      end else if (step == LAST_STEP) begin
        classify   = 1'b1;
        class_next = CLS_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD:          state_next = ST_RUN;
      ST_RUN:           if (classify) state_next = ST_REPORT;
      ST_REPORT:        if (result_ready) state_next = (seed == 8'hFF) ? ST_DONE : ST_LOAD;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    chk_reset    = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DONE);
    result_valid = (state == ST_REPORT);
    busy         = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_REPORT);
    done         = (state == ST_DONE);
  end

  assign handshake = result_valid && result_ready;

  // Status is frozen on the classifying edge so it stays stable through REPORT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seed          <= 8'h00;
      step          <= 9'd0;
      status        <= 8'h00;
      result_seed   <= 8'h00;
      result_class  <= 2'b00;
      result_steps  <= 9'd0;
      fixed_count   <= 9'd0;
      cycle_count   <= 9'd0;
      timeout_count <= 9'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            seed          <= FIRST_SEED;
            fixed_count   <= 9'd0;
            cycle_count   <= 9'd0;
            timeout_count <= 9'd0;
          end
        end
        ST_LOAD: begin
          status <= seed;
          step   <= 9'd0;
        end
        ST_RUN: begin
          if (classify) begin
            result_seed  <= seed;
            result_class <= class_next;
            result_steps <= step + 9'd1;
          end else begin
            status <= next_status;
            step   <= step + 9'd1;
          end
        end
        ST_REPORT: begin
          if (handshake) begin
            case (result_class)
              CLS_FIXED:   fixed_count   <= sat_inc(fixed_count);
              CLS_CYCLE:   cycle_count   <= sat_inc(cycle_count);
              CLS_TIMEOUT: timeout_count <= sat_inc(timeout_count);
              default:     ;
            endcase
            if (seed != 8'hFF) seed <= seed + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
